// File: rtl/tetris_agent_ctrl_if.sv
// Placement-engine handshake for the tetris player controller.
// Controller holds tile/board on a level request; engine answers with a one-cycle ack.
interface tetris_agent_ctrl_if #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int COL_IDX_W = 4
);
  logic                 eval_req;
  logic [3:0]           eval_tile;
  logic [ROWS*COLS-1:0] eval_board;
  logic                 eval_ack;
  logic [COL_IDX_W-1:0] eval_col;
  logic [1:0]           eval_rot;

  modport master (
    output eval_req, eval_tile, eval_board,
    input  eval_ack, eval_col, eval_rot
  );

  modport slave (
    input  eval_req, eval_tile, eval_board,
    output eval_ack, eval_col, eval_rot
  );
endinterface

// File: rtl/tetris_agent_ctrl.sv
// Tetris player controller: fetch board, ask placement engine, issue move.
// Optional macro TETRIS_TOPOUT_SKIP_EN: skip evaluation when row 0 is occupied.
module tetris_agent_ctrl #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int ROW_IDX_W = 6,
  parameter int COL_IDX_W = 4,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_ready,
  input  logic [3:0]           tile_type,
  output logic                 player_ready,
  output logic                 row_req,
  output logic [ROW_IDX_W-1:0] row,
  input  logic [COLS-1:0]      row_info,
  output logic [COL_IDX_W-1:0] col,
  output logic [1:0]           rotation,
  output logic                 set_tile,
  tetris_agent_ctrl_if.master  eng,
  output logic                 eval_timeout,
  output logic [CNT_W-1:0]     placed_cnt
`ifdef TETRIS_TOPOUT_SKIP_EN
  ,
  output logic                 topout
`endif
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int TOP  = (ROWS - 1) * COLS;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
  localparam logic [COL_IDX_W-1:0] COL_MAX  = COL_IDX_W'(COLS - 1);
  localparam logic [3:0]           LAT      = 4'(RD_LAT);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FREQ, S_FWAIT,
    S_EREQ, S_EWAIT, S_ISSUE, S_REARM
  } state_t;

  state_t state, state_nxt;

  logic [3:0]           wcnt;
  logic [TO_W-1:0]      tcnt;
  logic [ROWS*COLS-1:0] board;
  logic [3:0]           tile_q;
  logic                 sample;
  logic                 ack_hit;
  logic                 expire;

`ifdef TETRIS_TOPOUT_SKIP_EN
  logic            top_hit;
  logic [COLS-1:0] row0_now;

  // Row 0 may be the row being captured this very cycle
  assign row0_now = (row == '0) ? row_info : board[TOP +: COLS];
`endif

  assign eng.eval_req   = (state == S_EWAIT);
  assign eng.eval_tile  = tile_q;
  assign eng.eval_board = board;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_req   = 1'b0;
    set_tile  = 1'b0;
    sample    = 1'b0;
    ack_hit   = 1'b0;
    expire    = 1'b0;
`ifdef TETRIS_TOPOUT_SKIP_EN
    top_hit   = 1'b0;
`endif
    case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE: if (host_ready) state_nxt = S_FREQ;
      S_FREQ: begin
        if (host_ready) begin
          row_req   = 1'b1;
          state_nxt = S_FWAIT;
        end
      end
      S_FWAIT: begin
        if (wcnt == LAT) begin
          sample = 1'b1;
          if (row != LAST_ROW) begin
            state_nxt = S_FREQ;
`ifdef TETRIS_TOPOUT_SKIP_EN
          end else if (row0_now != '0) begin
            top_hit   = 1'b1;
            state_nxt = S_ISSUE;
`endif
          end else begin
            state_nxt = S_EREQ;
          end
        end
      end
      S_EREQ: state_nxt = S_EWAIT;
      S_EWAIT: begin
        if (eng.eval_ack) begin
          ack_hit   = 1'b1;
          state_nxt = S_ISSUE;
        end else if (tcnt == TO_LAST) begin
          expire    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (host_ready) begin
          set_tile  = 1'b1;
          state_nxt = S_REARM;
        end
      end
      S_REARM: if (!host_ready) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_ready <= 1'b0;
      row          <= '0;
      wcnt         <= '0;
      tcnt         <= '0;
      board        <= '0;
      tile_q       <= '0;
      col          <= '0;
      rotation     <= '0;
      eval_timeout <= 1'b0;
      placed_cnt   <= '0;
`ifdef TETRIS_TOPOUT_SKIP_EN
      topout       <= 1'b0;
`endif
    end else begin
      if (state == S_INIT) player_ready <= 1'b1;
      if (state == S_IDLE && host_ready) begin
        tile_q <= tile_type;
        row    <= '0;
      end
      if (row_req)               wcnt <= 4'd1;
      else if (state == S_FWAIT) wcnt <= wcnt + 4'd1;
      for (int r = 0; r < ROWS; r++) begin
        if (sample && row == ROW_IDX_W'(r))
          board[(ROWS-1-r)*COLS +: COLS] <= row_info;
      end
      if (sample && row != LAST_ROW) row <= row + 1'b1;
      if (state == S_EREQ)       tcnt <= '0;
      else if (state == S_EWAIT) tcnt <= tcnt + 1'b1;
      if (ack_hit) begin
        col      <= (eng.eval_col > COL_MAX) ? COL_MAX : eng.eval_col;
        rotation <= eng.eval_rot;
      end
      if (expire) begin
        col          <= '0;
        rotation     <= '0;
        eval_timeout <= 1'b1;
      end
`ifdef TETRIS_TOPOUT_SKIP_EN
      if (top_hit) begin
        col      <= '0;
        rotation <= '0;
        topout   <= 1'b1;
      end
`endif
      if (set_tile) placed_cnt <= placed_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tetris_agent_ctrl.sv
// Randomised scoreboard bench for tetris_agent_ctrl: host and engine models,
// expectations queued at stimulus time and popped by a negedge monitor.
module tb_tetris_agent_ctrl;
  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int ROW_IDX_W = 6;
  localparam int COL_IDX_W = 4;
  localparam int RD_LAT    = 1;
  localparam int TIMEOUT   = 16;
  localparam int CNT_W     = 16;
  localparam int BW        = ROWS * COLS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 host_ready;
  logic [3:0]           tile_type;
  logic                 player_ready;
  logic                 row_req;
  logic [ROW_IDX_W-1:0] row;
  logic [COLS-1:0]      row_info;
  logic [COL_IDX_W-1:0] col;
  logic [1:0]           rotation;
  logic                 set_tile;
  logic                 eval_timeout;
  logic [CNT_W-1:0]     placed_cnt;
`ifdef TETRIS_TOPOUT_SKIP_EN
  logic                 topout;
`endif

  tetris_agent_ctrl_if #(
    .COLS(COLS), .ROWS(ROWS), .COL_IDX_W(COL_IDX_W)
  ) eif ();

  tetris_agent_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ROW_IDX_W(ROW_IDX_W),
    .COL_IDX_W(COL_IDX_W), .RD_LAT(RD_LAT),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host_ready(host_ready),
    .tile_type(tile_type),
    .player_ready(player_ready),
    .row_req(row_req),
    .row(row),
    .row_info(row_info),
    .col(col),
    .rotation(rotation),
    .set_tile(set_tile),
    .eng(eif.master),
    .eval_timeout(eval_timeout),
    .placed_cnt(placed_cnt)
`ifdef TETRIS_TOPOUT_SKIP_EN
    ,
    .topout(topout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] tile; logic [BW-1:0] board; } ereq_t;
  typedef struct { int col; int rot; int len; int tmo; } eres_t;
  typedef struct { int due; int r; } rd_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rows_seen = 0;
  int sets_seen = 0;
  int eng_mode = 0;
  int model_cnt = 0;
  int tmo_model = 0;
  int last_rr = 0;
  bit no_stall = 0;
  bit cnt_chk = 0;

  logic [COLS-1:0] hboard [ROWS];
  int    row_q [$];
  ereq_t ereq_q [$];
  eres_t len_q [$];
  eres_t set_q [$];
  rd_t   rd_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Host row port: requested row appears RD_LAT cycles later, noise otherwise
  initial begin
    row_info = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        row_info = hboard[rd_q[0].r];
        void'(rd_q.pop_front());
      end else begin
        row_info = COLS'($urandom);
      end
    end
  end

  // Placement engine: ack after d cycles of eval_req (d >= TIMEOUT is too late)
  initial begin
    bit eng_prev;
    int d, c, r;
    eres_t e;
    eng_prev = 0;
    eif.eval_ack = 1'b0;
    eif.eval_col = '0;
    eif.eval_rot = '0;
    forever begin
      @(negedge clk);
      if (eif.eval_req && !eng_prev) begin
        case (eng_mode)
          1: begin d = 5; c = 9; r = 2; end
          2: begin d = $urandom_range(1, 8); c = 12; r = $urandom_range(0, 3); end
          3: begin d = TIMEOUT + 3; c = 7; r = 3; end
          4: begin d = TIMEOUT - 1; c = $urandom_range(0, 15); r = $urandom_range(0, 3); end
          default: begin
            d = $urandom_range(1, TIMEOUT + 3);
            c = $urandom_range(0, 15);
            r = $urandom_range(0, 3);
          end
        endcase
        if (d <= TIMEOUT - 1) begin
          e.col = (c > COLS - 1) ? COLS - 1 : c;
          e.rot = r;
          e.len = d + 1;
        end else begin
          e.col = 0;
          e.rot = 0;
          e.len = TIMEOUT;
          tmo_model = 1;
        end
        e.tmo = tmo_model;
        len_q.push_back(e);
        set_q.push_back(e);
        repeat (d) begin
          @(posedge clk);
          #1;
          eif.eval_col = COL_IDX_W'($urandom);
          eif.eval_rot = 2'($urandom);
        end
        eif.eval_ack = 1'b1;
        eif.eval_col = COL_IDX_W'(c);
        eif.eval_rot = 2'(r);
        @(posedge clk);
        #1;
        eif.eval_ack = 1'b0;
        eng_prev = 1;
      end else begin
        eng_prev = eif.eval_req;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event
  initial begin
    bit prev_req;
    int len;
    int er;
    ereq_t q;
    eres_t s;
    prev_req = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (row_req || set_tile) chk("excl", int'(row_req & set_tile), 0);
      if (row_req) begin
        rows_seen++;
        if (no_stall && row != '0) chk("row_gap", cyc - last_rr, RD_LAT + 1);
        last_rr = cyc;
        if (row_q.size() == 0) begin
          chk("row_unexp", int'(row), -1);
        end else begin
          er = row_q.pop_front();
          chk("row_idx", int'(row), er);
        end
        rd_q.push_back('{cyc + RD_LAT, int'(row)});
      end
      if (eif.eval_req && !prev_req) begin
        len = 1;
        if (ereq_q.size() == 0) begin
          chk("ereq_unexp", 1, 0);
        end else begin
          q = ereq_q.pop_front();
          chk("eval_tile", int'(eif.eval_tile), int'(q.tile));
          chk_w("eval_board", eif.eval_board, q.board);
        end
      end else if (eif.eval_req) begin
        len++;
      end
      if (!eif.eval_req && prev_req) begin
        if (len_q.size() == 0) begin
          chk("elen_unexp", len, -1);
        end else begin
          s = len_q.pop_front();
          chk("ereq_len", len, s.len);
        end
      end
      prev_req = eif.eval_req;
      if (set_tile) begin
        sets_seen++;
        if (set_q.size() == 0) begin
          chk("set_unexp", 1, 0);
        end else begin
          s = set_q.pop_front();
          chk("col", int'(col), s.col);
          chk("rotation", int'(rotation), s.rot);
          chk("eval_timeout", int'(eval_timeout), s.tmo);
          chk("placed_pre", int'(placed_cnt), model_cnt);
          model_cnt = (model_cnt + 1) % (1 << CNT_W);
          cnt_chk = 1;
        end
      end else if (cnt_chk) begin
        chk("placed_cnt", int'(placed_cnt), model_cnt);
        cnt_chk = 0;
      end
    end
  end

  task automatic do_move(input int mode, input int tile, input int kind,
                         input int abort_row);
    logic [BW-1:0] eb;
    ereq_t e;
    int base_r, base_s, n;
    for (int r = 0; r < ROWS; r++) begin
      case (kind)
        0: hboard[r] = '0;
        1: hboard[r] = (r == ROWS - 1) ? 10'b1111111110 : '0;
        default: hboard[r] = ($urandom_range(0, 2) == 0) ? '0 : COLS'($urandom);
      endcase
`ifdef TETRIS_TOPOUT_SKIP_EN
      if (r == 0) hboard[r] = '0;
`endif
    end
    eb = '0;
    for (int r = 0; r < ROWS; r++) eb[(ROWS-1-r)*COLS +: COLS] = hboard[r];
    e.tile = 4'(tile);
    e.board = eb;
    ereq_q.push_back(e);
    for (int r = 0; r < ROWS; r++) row_q.push_back(r);
    eng_mode = mode;
    @(posedge clk);
    #1;
    host_ready = 1'b0;
    @(posedge clk);
    #1;
    host_ready = 1'b1;
    tile_type = 4'(tile);
    base_r = rows_seen;
    base_s = sets_seen;
    n = 0;
    while (rows_seen < base_r + ROWS && n < 3000) begin
      @(posedge clk);
      #1;
      host_ready = no_stall ? 1'b1 : ($urandom_range(0, 3) != 0);
      tile_type = 4'($urandom);
      n++;
      if (abort_row >= 0 && rows_seen == base_r + abort_row + 1) return;
    end
    if (n >= 3000) chk("fetch_bound", rows_seen - base_r, ROWS);
    n = 0;
    while (sets_seen == base_s && n < 500) begin
      @(posedge clk);
      #1;
      host_ready = ($urandom_range(0, 2) != 0);
      n++;
    end
    if (n >= 500) chk("issue_bound", sets_seen - base_s, 1);
    host_ready = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    chk("rows_left", row_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, int'(player_ready), 0);
    chk({tag, "_row_req"}, int'(row_req), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_eval_req"}, int'(eif.eval_req), 0);
    chk({tag, "_eval_tile"}, int'(eif.eval_tile), 0);
    chk({tag, "_set_tile"}, int'(set_tile), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_rot"}, int'(rotation), 0);
    chk({tag, "_tmo"}, int'(eval_timeout), 0);
    chk({tag, "_cnt"}, int'(placed_cnt), 0);
    chk_w({tag, "_board"}, eif.eval_board, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    host_ready = 1'b0;
    tile_type = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_pre", int'(player_ready), 0);
    @(negedge clk);
    chk("ready_post", int'(player_ready), 1);

    no_stall = 1;
    do_move(0, 3, 0, -1);
    no_stall = 0;
    do_move(1, $urandom_range(0, 15), 1, -1);
    do_move(2, $urandom_range(0, 15), 2, -1);
    do_move(3, $urandom_range(0, 15), 2, -1);
    do_move(4, $urandom_range(0, 15), 2, -1);
    for (int i = 0; i < 10; i++) do_move(0, $urandom_range(0, 15), 2, -1);

    do_move(0, $urandom_range(0, 15), 2, 7);
    reset = 1'b1;
    #1;
    reset_checks("abort");
    row_q.delete();
    rd_q.delete();
    ereq_q.delete();
    len_q.delete();
    set_q.delete();
    model_cnt = 0;
    tmo_model = 0;
    cnt_chk = 0;
    host_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_rel0", int'(player_ready), 0);
    @(negedge clk);
    chk("ready_rel1", int'(player_ready), 1);
    do_move(0, $urandom_range(0, 15), 2, -1);
    do_move(1, $urandom_range(0, 15), 2, -1);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tetris_agent_ctrl.md
Name: tetris_agent_ctrl

Overview:
Parametrised next-generation player controller for the tetris host interface.
- Per move: latches the incoming tile, reads the whole board row by row over the host row port, and stores it in an internal flattened board.
- Hands tile and board to an external placement engine over a req/ack handshake with timeout fallback, then issues the chosen column/rotation to the host with a set_tile pulse.
- Generalised over board size and host read latency; adds clamping, timeout and a placement counter.

Parameters:
COLS, 10, board width in cells.
ROWS, 20, board height in rows (row 0 = top).
ROW_IDX_W, 6, width of row index; must hold ROWS-1.
COL_IDX_W, 4, width of column index; must hold COLS-1.
RD_LAT, 1, host cycles from row_req pulse to valid row_info (1..7).
TIMEOUT, 1024, max cycles waiting for eval_ack before fallback.
CNT_W, 16, width of placement counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_ready  in  1  host idle and able to accept a request.
- tile_type  in  4  current tile, valid while host_ready=1 in IDLE.
- player_ready  out  1  controller alive.
- row_req  out  1  one-cycle row read strobe.
- row  out  ROW_IDX_W  row index being read.
- row_info  in  COLS  row contents; MSB = leftmost cell.
- col  out  COL_IDX_W  leftmost anchor column of placement.
- rotation  out  2  rotation 0..3.
- set_tile  out  1  one-cycle placement strobe.
- eval_req  out  1  level request to placement engine.
- eval_tile  out  4  tile under evaluation.
- eval_board  out  ROWS*COLS  captured board; row r occupies bits [(ROWS-1-r)*COLS +: COLS].
- eval_ack  in  1  one-cycle engine completion pulse.
- eval_col  in  COL_IDX_W  engine column, sampled with eval_ack.
- eval_rot  in  2  engine rotation, sampled with eval_ack.
- eval_timeout  out  1  sticky: a timeout fallback has occurred.
- placed_cnt  out  CNT_W  number of set_tile pulses issued, wraps.

Behaviour:
Reset values: all outputs 0, internal board 0, state INIT. Reset asserted mid-operation aborts the move immediately; no set_tile is issued.

State machine:
- INIT: player_ready<=1 -> IDLE. player_ready stays 1 until the next reset.
- IDLE: on host_ready=1, latch tile_type into eval_tile, clear row counter -> FETCH_REQ.
- FETCH_REQ: if host_ready=1, row_req=1 for exactly one cycle with row=counter -> FETCH_WAIT. If host_ready=0, stall with row_req=0.
- FETCH_WAIT: count RD_LAT cycles after the row_req cycle, then write row_info into board row[counter].
  - counter==ROWS-1 -> EVAL_REQ.
  - otherwise counter+1 -> FETCH_REQ.
  - Minimum fetch time: ROWS*(RD_LAT+1) cycles.
- EVAL_REQ: eval_req<=1, clear timeout counter -> EVAL_WAIT. eval_board and eval_tile stay stable while eval_req=1.
- EVAL_WAIT: on eval_ack:
  - latch col = min(eval_col, COLS-1) and rotation = eval_rot.
  - eval_req<=0 -> ISSUE.
  - On timeout counter reaching TIMEOUT-1 with no ack: col<=0, rotation<=0, eval_timeout<=1, eval_req<=0 -> ISSUE.
  - Ack in the same cycle as expiry: ack wins, eval_timeout unchanged.
- ISSUE: when host_ready=1, set_tile=1 for one cycle, placed_cnt+1 (wraps to 0 at 2^CNT_W) -> REARM. col/rotation stable from entry to ISSUE until the next EVAL result.
- REARM: wait for host_ready=0 for at least one cycle -> IDLE. This prevents double-issue on the same host_ready level.

Other rules:
- eval_ack outside EVAL_WAIT is ignored.
- row_info is ignored outside the sampling cycle.
- row_req and set_tile are never high in the same cycle.

Optional Feature:
Macro TETRIS_TOPOUT_SKIP_EN.
- Defined: at the end of FETCH, if captured row 0 is nonzero, skip EVAL.
  - Go directly to ISSUE with col=0, rotation=0, eval_req never asserted.
  - Adds output topout (1 bit, reset 0), set sticky in that case.
- Undefined: no topout port, and row 0 contents do not affect flow.

Test Plan:
- Reset, then host_ready=1, tile_type=3, RD_LAT=1, all rows 0 -> 20 row_req pulses with row 0..19 spaced 2 cycles apart; eval_req rises with eval_tile=3 and eval_board=0.
- Row 19 = 10'b1111111110, engine acks eval_col=9, eval_rot=2 after 5 cycles -> eval_board[9:0]=10'b1111111110; one set_tile pulse with col=9, rotation=2; placed_cnt=1.
- Engine acks eval_col=12 -> col=9 (clamped).
- Engine never acks, TIMEOUT=16 -> eval_req drops 16 cycles after rising; set_tile with col=0, rotation=0; eval_timeout=1 and stays 1 across later moves.
- host_ready held high after set_tile -> no second fetch until host_ready goes 0 then 1. host_ready=0 during FETCH_REQ -> row_req stalls, then resumes at the same row.
- Assert reset during FETCH_WAIT at row 7 -> all outputs 0 asynchronously, board cleared, player_ready returns to 1 one cycle after release.
